ioctl_upload_server: RTL

//  Serves HPS ioctl upload reads (core -> HPS), e.g. hiscore/NVRAM save; the read-side counterpart of ROM download.

---
 rtl/galivan_pkg.sv | 20 ++
 rtl/ioctl_upload_server.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/galivan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | galivan_pkg                                                                |
// | Shared ioctl index constants and the upload-server state encoding.         |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package galivan_pkg;

  localparam logic [7:0] UPLOAD_IDX_HISCORE = 8'd4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_LO   = 3'd2,
    S_HI   = 3'd3,
    S_DONE = 3'd4
  } upload_state_e;

endpackage
`default_nettype wire

// File: rtl/ioctl_upload_server.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ioctl_upload_server                                                        |
// | Serves HPS ioctl upload reads as two byte reads of an arbitrated RAM port. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module ioctl_upload_server
  import galivan_pkg::*;
#(
  parameter logic [7:0] UPLOAD_INDEX = UPLOAD_IDX_HISCORE,
  parameter int         AW           = 11,
  parameter int         SIZE_BYTES   = 2048,
  parameter int         RD_LAT       = 1
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_rd,
  input  logic [26:0]   ioctl_addr,
  output logic [15:0]   ioctl_din,
  output logic          ioctl_wait,
  output logic          ram_req,
  input  logic          ram_gnt,
  output logic [AW-1:0] ram_addr,
  input  logic [7:0]    ram_dout,
  output logic          upload_done
);

  localparam logic [26:0]   c_size_full = 27'(SIZE_BYTES);
  localparam logic [AW:0]   c_size_ext  = (AW+1)'(SIZE_BYTES);
  localparam logic [1:0]    c_lat_m1    = 2'(RD_LAT - 1);

  upload_state_e r_state;
  logic [AW-1:0] r_a;
  logic [1:0]    r_cnt;
  logic [7:0]    r_lo;
  logic          r_skip;
  logic          r_active_d;

  logic          w_active;
  logic [26:0]   w_word_addr;
  logic          w_oor;
  logic          w_hi_oor;
  logic          w_busy;
  logic          w_unused_addr0;

  assign w_active       = ioctl_upload & (ioctl_index == UPLOAD_INDEX);
  assign w_word_addr    = {ioctl_addr[26:1], 1'b0};
  assign w_oor          = (w_word_addr >= c_size_full);
  assign w_hi_oor       = ({1'b0, r_a[AW-1:1], 1'b1} >= c_size_ext);
  assign w_unused_addr0 = ioctl_addr[0];

  // An out-of-range word keeps wait high through its DONE cycle.
  assign w_busy = (r_state == S_REQ) | (r_state == S_LO) | (r_state == S_HI) |
                  ((r_state == S_DONE) & r_skip);
  assign ioctl_wait = w_busy | ((r_state == S_IDLE) & ioctl_rd & w_active);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_cnt       <= '0;
      r_lo        <= '0;
      r_skip      <= 1'b0;
      r_active_d  <= 1'b0;
      ioctl_din   <= '0;
      ram_req     <= 1'b0;
      ram_addr    <= '0;
      upload_done <= 1'b0;
    end else begin
      r_active_d  <= w_active;
      upload_done <= r_active_d & ~w_active;

      if ((r_state != S_IDLE) && !w_active) begin
        r_state <= S_IDLE;
        ram_req <= 1'b0;
        r_skip  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (ioctl_rd && w_active) begin
              r_a <= {ioctl_addr[AW-1:1], 1'b0};
              if (w_oor) begin
                ioctl_din <= 16'hFFFF;
                r_skip    <= 1'b1;
                r_state   <= S_DONE;
              end else begin
                r_skip  <= 1'b0;
                ram_req <= 1'b1;
                r_state <= S_REQ;
              end
            end
          end
          S_REQ: begin
            if (ram_gnt) begin
              ram_addr <= r_a;
              r_cnt    <= c_lat_m1;
              r_state  <= S_LO;
            end
          end
          S_LO: begin
            // ram_addr[0] tells whether A+1 has already been presented.
            if (!ram_gnt) begin
              r_state <= S_REQ;
            end else if (!ram_addr[0]) begin
              if (r_cnt == 2'd0) ram_addr <= {r_a[AW-1:1], 1'b1};
              else               r_cnt    <= r_cnt - 2'd1;
            end else begin
              r_lo    <= ram_dout;
              r_cnt   <= c_lat_m1;
              r_state <= S_HI;
            end
          end
          S_HI: begin
            if (!ram_gnt) begin
              r_state <= S_REQ;
            end else if (w_hi_oor || (r_cnt == 2'd0)) begin
              ioctl_din <= {(w_hi_oor ? 8'hFF : ram_dout), r_lo};
              ram_req   <= 1'b0;
              r_state   <= S_DONE;
            end else begin
              r_cnt <= r_cnt - 2'd1;
            end
          end
          S_DONE: begin
            r_skip  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            ram_req <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
